// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU sequencing FSM with registered outputs; define ALU_SEQ_STALL_EN to add the stall port
module alu_seq_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] imm,
`ifdef ALU_SEQ_STALL_EN
  input  logic             stall,
`endif
  output logic [1:0]       mux_sel,
  output logic [2:0]       alu_op,
  output logic             acc_we,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0] mux_sel_d;
  logic [2:0] alu_op_d;
  logic acc_we_d, done_d, err_d, hold;
`ifdef ALU_SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif
  // outputs are computed for the state being entered and registered with it
  always_comb begin
    state_d = state;
    cnt_d = '0;
    mux_sel_d = 2'd0;
    alu_op_d = 3'd0;
    acc_we_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        if (op[2]) err_d = 1'b1;
        else if (op != 3'd3) begin
          state_d = EXEC;
          mux_sel_d = op[1:0];
          alu_op_d = op;
          acc_we_d = 1'b1;
        end else if (imm != '0) begin
          state_d = ITER;
          cnt_d = imm;
          mux_sel_d = 2'd3;
          alu_op_d = 3'd3;
          acc_we_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      EXEC: begin
        state_d = DONE;
        done_d = 1'b1;
      end
      ITER: if (iter_cnt > CNT_W'(1)) begin
        cnt_d = iter_cnt - CNT_W'(1);
        mux_sel_d = 2'd3;
        alu_op_d = 3'd3;
        acc_we_d = 1'b1;
      end else begin
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a stalled edge freezes progress and suppresses all side effects
    if (hold) begin
      state_d = state;
      cnt_d = iter_cnt;
      mux_sel_d = mux_sel;
      alu_op_d = alu_op;
      acc_we_d = 1'b0;
      done_d = 1'b0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter_cnt <= '0;
      mux_sel <= 2'd0;
      alu_op <= 3'd0;
      acc_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      iter_cnt <= cnt_d;
      mux_sel <= mux_sel_d;
      alu_op <= alu_op_d;
      acc_we <= acc_we_d;
      busy <= state_d != IDLE;
      done <= done_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic reset, start, stall;
  logic [2:0] op, imm, alu_op, iter_cnt;
  logic [1:0] mux_sel;
  logic acc_we, busy, done, err;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_seq_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .imm(imm),
`ifdef ALU_SEQ_STALL_EN
    .stall(stall),
`endif
    .mux_sel(mux_sel), .alu_op(alu_op), .acc_we(acc_we), .busy(busy),
    .done(done), .err(err), .iter_cnt(iter_cnt)
  );
  // packed order: mux_sel, alu_op, acc_we, busy, done, err, iter_cnt
  function automatic logic [11:0] v(logic [1:0] m, logic [2:0] a, logic w, logic b, logic d, logic e, logic [2:0] c);
    return {m, a, w, b, d, e, c};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [11:0] exp);
    logic [11:0] obs;
    obs = {mux_sel, alu_op, acc_we, busy, done, err, iter_cnt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; op = 3'd0; imm = 3'd0;
    step();
    step();
    chk("reset", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd5;
    step();
    chk("reset_over_start", v(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0; op = 3'd1;
    step();
    start = 1'b0;
    chk("lsr_exec", v(1, 1, 1, 1, 0, 0, 0));
    step();
    chk("lsr_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("lsr_idle", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd3; imm = 3'd5;
    step();
    start = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      chk($sformatf("iter5_%0d", k), v(3, 3, 1, 1, 0, 0, 3'(k)));
      step();
    end
    chk("iter5_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("iter5_idle", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; imm = 3'd0;
    step();
    start = 1'b0;
    chk("imm0_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("imm0_idle", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd6;
    step();
    start = 1'b0;
    chk("illegal_err", v(0, 0, 0, 0, 0, 1, 0));
    step();
    chk("illegal_clear", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd3; imm = 3'd7;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_iter3", v(3, 3, 1, 1, 0, 0, 5));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_reset", v(0, 0, 0, 0, 0, 0, 0));
    step();
    chk("abort_no_done", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd0;
    step();
    start = 1'b0;
    chk("reg_exec", v(0, 0, 1, 1, 0, 0, 0));
    step();
    chk("reg_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("reg_idle", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd2;
    step();
    op = 3'd1;
    chk("dump_exec", v(2, 2, 1, 1, 0, 0, 0));
    step();
    chk("busy_start_ignored", v(0, 0, 0, 1, 1, 0, 0));
    step();
    start = 1'b0;
    chk("done_start_ignored", v(0, 0, 0, 0, 0, 0, 0));
    step();
    chk("dump_idle", v(0, 0, 0, 0, 0, 0, 0));
    start = 1'b1; op = 3'd3; imm = 3'd7;
    step();
    start = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      chk($sformatf("iter7_%0d", k), v(3, 3, 1, 1, 0, 0, 3'(k)));
      step();
    end
    chk("iter7_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    chk("iter7_idle", v(0, 0, 0, 0, 0, 0, 0));
`ifdef ALU_SEQ_STALL_EN
    start = 1'b1; imm = 3'd4;
    step();
    start = 1'b0;
    chk("stall_it4", v(3, 3, 1, 1, 0, 0, 4));
    step();
    chk("stall_it3", v(3, 3, 1, 1, 0, 0, 3));
    stall = 1'b1;
    step();
    chk("stall_hold1", v(3, 3, 0, 1, 0, 0, 3));
    step();
    chk("stall_hold2", v(3, 3, 0, 1, 0, 0, 3));
    stall = 1'b0;
    step();
    chk("stall_it2", v(3, 3, 1, 1, 0, 0, 2));
    step();
    chk("stall_it1", v(3, 3, 1, 1, 0, 0, 1));
    step();
    chk("stall_done", v(0, 0, 0, 1, 1, 0, 0));
    step();
    stall = 1'b1; start = 1'b1; op = 3'd0;
    step();
    chk("stall_start_ignored", v(0, 0, 0, 0, 0, 0, 0));
    stall = 1'b0; start = 1'b0;
    step();
    chk("stall_idle", v(0, 0, 0, 0, 0, 0, 0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 3: width of the iteration count and the immediate field.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 start  input  1  request to begin one operation; accepted only in IDLE.
REQ-005 op  input  3  operation class: 0 REG, 1 LSR, 2 DUMP, 3 LSL_ITER, 4-7 illegal.
REQ-006 imm  input  CNT_W  iteration count for LSL_ITER; ignored for other ops.
REQ-007 stall  input  1  freeze request; present only when ALU_SEQ_STALL_EN is defined.
REQ-008 mux_sel  output  2  ALU operand-mux select: 0 register, 1 lsr immediate, 2 dump r0, 3 constant 1.
REQ-009 alu_op  output  3  ALU function code for the current cycle.
REQ-010 acc_we  output  1  accumulator/register write enable for the current ALU result.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse marking operation completion.
REQ-013 err  output  1  one-cycle pulse on acceptance of an illegal op.
REQ-014 iter_cnt  output  CNT_W  iterations remaining, for debug and trace.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, EXEC, ITER and DONE; all outputs SHALL be registered.
REQ-016 In IDLE with start=1, the block SHALL latch op and imm and transition as follows: op 0-2 to EXEC; op 3 with imm>0 to ITER; op 3 with imm=0 to DONE; op 4-7 to IDLE, with err=1 for one cycle.
REQ-017 EXEC SHALL last one cycle and drive the following outputs: mux_sel=op[1:0], alu_op=op and acc_we=1; it SHALL then transition to DONE.
REQ-018 ITER SHALL drive mux_sel=3, alu_op=3 and acc_we=1 in every cycle.
REQ-019 In ITER, iter_cnt SHALL load imm on entry and decrement by 1 per cycle; the FSM SHALL leave ITER for DONE in the cycle in which iter_cnt=1, giving exactly imm write cycles.
REQ-020 DONE SHALL last one cycle with done=1 and acc_we=0, then return to IDLE.
REQ-021 Latency from start accepted at edge N: single-cycle ops have acc_we at N+1 and done at N+2; LSL_ITER has acc_we at N+1..N+imm and done at N+imm+1.
REQ-022 With LSL_ITER and imm=0, acc_we SHALL never assert and done SHALL assert at N+1.
REQ-023 start while busy=1 SHALL be ignored, with no queuing; start in the DONE cycle SHALL also be ignored.
REQ-024 In IDLE, outputs SHALL be mux_sel=0, alu_op=0, acc_we=0 and iter_cnt=0.
REQ-025 iter_cnt SHALL never wrap below 0; imm=2^CNT_W-1 SHALL complete normally.

Reset
REQ-026 When reset=1 at a rising edge, the FSM SHALL enter IDLE and all outputs SHALL be 0 the following cycle, regardless of state, including mid-ITER.
REQ-027 reset SHALL take priority over start and stall; an aborted operation SHALL NOT produce done.

Configuration
REQ-028 The macro ALU_SEQ_STALL_EN, when defined, SHALL add the stall port.
REQ-029 While stall=1, state, iter_cnt, mux_sel and alu_op SHALL hold; acc_we, done and err SHALL be forced to 0; and start SHALL be ignored.
REQ-030 After stall deasserts, the block SHALL resume in the held state, so an operation completes exactly as if unstalled, extended by the number of stalled cycles.
REQ-031 When ALU_SEQ_STALL_EN is undefined, the stall port SHALL be absent and behaviour SHALL equal that with stall tied to 0.

Verification
REQ-032 Start with op=1 in IDLE -> next cycle mux_sel=1, acc_we=1; following cycle done=1; then busy=0.
REQ-033 Start with op=3, imm=5 -> acc_we high for exactly 5 consecutive cycles with mux_sel=3 and iter_cnt 5,4,3,2,1; done in the 6th cycle.
REQ-034 Start with op=3, imm=0 -> no acc_we; done=1 the next cycle. Start with op=6 -> err=1 for one cycle; busy stays 0.
REQ-035 Assert reset during the 3rd ITER cycle of imm=7 -> all outputs 0 the next cycle; no done; a new op=0 start is then accepted normally.
REQ-036 Pulse start during EXEC and during DONE -> both ignored; exactly one done observed.
REQ-037 With ALU_SEQ_STALL_EN defined, apply stall for 2 cycles mid-ITER with imm=4 -> 4 acc_we cycles total; done is delayed by exactly 2 cycles.
